// File: rtl/itcm_resp.sv
// Instruction TCM responder: accepts fetch PCs, returns the addressed word after a fixed
// latency with misalign / bus-error flags. Flush cancels any in-flight fetch.
module itcm_resp #(
  parameter int unsigned          PC_WIDTH    = 64,
  parameter int unsigned          INSTR_WIDTH = 32,
  parameter int unsigned          DEPTH_LOG2  = 12,
  parameter logic [PC_WIDTH-1:0]  BASE_ADDR   = 64'h8000_0000,
  parameter int unsigned          LATENCY     = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [PC_WIDTH-1:0]    req_pc_i,
  input  logic                   flush_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [INSTR_WIDTH-1:0] rsp_instr_o,
  output logic                   rsp_misalign_o,
  output logic                   rsp_bus_err_o,
  input  logic                   wr_en_i,
  input  logic [DEPTH_LOG2-1:0]  wr_addr_i,
  input  logic [INSTR_WIDTH-1:0] wr_data_i
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  // One extra bit so the end-of-array bound cannot wrap for bases near the top of the space.
  localparam logic [PC_WIDTH:0] LoAddr = {1'b0, BASE_ADDR};
  localparam logic [PC_WIDTH:0] HiAddr = LoAddr + ((PC_WIDTH + 1)'(1) << (DEPTH_LOG2 + 2));
  localparam logic [3:0] CntInit = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [INSTR_WIDTH-1:0]  instr_q, instr_d;
  logic                    misalign_q, misalign_d;
  logic                    bus_err_q, bus_err_d;
  logic [INSTR_WIDTH-1:0]  mem_q [Depth];

  logic                    accept;
  logic                    req_misalign;
  logic                    req_bus_err;
  logic [DEPTH_LOG2-1:0]   req_idx;

  assign req_misalign = req_pc_i[1:0] != 2'b00;
  assign req_bus_err  = !req_misalign &
                        (({1'b0, req_pc_i} < LoAddr) | ({1'b0, req_pc_i} >= HiAddr));
  assign req_idx      = DEPTH_LOG2'((req_pc_i - BASE_ADDR) >> 2);
  assign accept       = req_valid_i & req_ready_o;

  // Array has no reset; reads below see the pre-edge contents, so same-edge writes are not seen.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      instr_q    <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      instr_q    <= instr_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    instr_d    = instr_q;
    misalign_d = misalign_q;
    bus_err_d  = bus_err_q;
    if (flush_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: ;
        StWait: begin
          if (cnt_q == 4'd0) begin
            instr_d = mem_q[idx_q];
            state_d = StResp;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        StResp: begin
          if (rsp_ready_i) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
      // Accept is only possible from IDLE or a completing RESP, so it overrides the above.
      if (accept) begin
        misalign_d = req_misalign;
        bus_err_d  = req_bus_err;
        idx_d      = req_idx;
        if (req_misalign || req_bus_err) begin
          instr_d = '0;
          state_d = StResp;
        end else if (LATENCY == 1) begin
          instr_d = mem_q[req_idx];
          state_d = StResp;
        end else begin
          cnt_d   = CntInit;
          state_d = StWait;
        end
      end
    end
  end

  always_comb begin
    req_ready_o    = !flush_i & ((state_q == StIdle) | ((state_q == StResp) & rsp_ready_i));
    rsp_valid_o    = state_q == StResp;
    rsp_instr_o    = instr_q;
    rsp_misalign_o = misalign_q;
    rsp_bus_err_o  = bus_err_q;
  end

endmodule

// File: tb/tb_itcm_resp.sv
// Drives a LATENCY=2 and a LATENCY=1 responder with shared stimulus and checks both
// against a transaction-level model of the fetch timing and array contents.
module tb_itcm_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [63:0] req_pc;
  logic        flush;
  logic        rsp_ready;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;

  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_instr [2];
  logic        rsp_mis   [2];
  logic        rsp_err   [2];

  int total = 0;
  int bad   = 0;

  // Model: per-DUT pending fetch with the edge number its data is due, plus the presented response.
  logic [31:0] ref_mem [4096];
  logic        m_pend  [2];
  logic        m_valid [2];
  int          m_due   [2];
  logic [11:0] m_idx   [2];
  logic [31:0] m_instr [2];
  logic        m_mis   [2];
  logic        m_err   [2];
  int          cyc = 0;

  always #5 clk = ~clk;

  itcm_resp #(.LATENCY(2)) u_dut_l2 (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready[0]),
    .req_pc_i      (req_pc),
    .flush_i       (flush),
    .rsp_valid_o   (rsp_valid[0]),
    .rsp_ready_i   (rsp_ready),
    .rsp_instr_o   (rsp_instr[0]),
    .rsp_misalign_o(rsp_mis[0]),
    .rsp_bus_err_o (rsp_err[0]),
    .wr_en_i       (wr_en),
    .wr_addr_i     (wr_addr),
    .wr_data_i     (wr_data)
  );

  itcm_resp #(.LATENCY(1)) u_dut_l1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready[1]),
    .req_pc_i      (req_pc),
    .flush_i       (flush),
    .rsp_valid_o   (rsp_valid[1]),
    .rsp_ready_i   (rsp_ready),
    .rsp_instr_o   (rsp_instr[1]),
    .rsp_misalign_o(rsp_mis[1]),
    .rsp_bus_err_o (rsp_err[1]),
    .wr_en_i       (wr_en),
    .wr_addr_i     (wr_addr),
    .wr_data_i     (wr_data)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pend[d]  = 1'b0;
      m_valid[d] = 1'b0;
      m_instr[d] = '0;
      m_mis[d]   = 1'b0;
      m_err[d]   = 1'b0;
    end
  endtask

  // Check outputs mid-cycle, predict the next edge, then commit after it.
  task automatic step();
    logic        n_pend  [2];
    logic        n_valid [2];
    int          n_due   [2];
    logic [11:0] n_idx   [2];
    logic [31:0] n_instr [2];
    logic        n_mis   [2];
    logic        n_err   [2];
    logic        rdy;
    logic        mis;
    logic        err;
    logic [63:0] off;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      rdy = !flush && ((!m_pend[d] && !m_valid[d]) || (m_valid[d] && rsp_ready));
      check_eq($sformatf("d%0d_ready", d), 64'(req_ready[d]), 64'(rdy));
      check_eq($sformatf("d%0d_valid", d), 64'(rsp_valid[d]), 64'(m_valid[d]));
      if (m_valid[d]) begin
        check_eq($sformatf("d%0d_instr", d), 64'(rsp_instr[d]), 64'(m_instr[d]));
        check_eq($sformatf("d%0d_misalign", d), 64'(rsp_mis[d]), 64'(m_mis[d]));
        check_eq($sformatf("d%0d_bus_err", d), 64'(rsp_err[d]), 64'(m_err[d]));
      end
      n_pend[d] = m_pend[d];  n_valid[d] = m_valid[d]; n_due[d] = m_due[d];
      n_idx[d]  = m_idx[d];   n_instr[d] = m_instr[d]; n_mis[d] = m_mis[d];
      n_err[d]  = m_err[d];
      if (!rst_n) begin
        n_pend[d] = 1'b0; n_valid[d] = 1'b0; n_instr[d] = '0; n_mis[d] = 1'b0; n_err[d] = 1'b0;
      end else if (flush) begin
        n_pend[d]  = 1'b0;
        n_valid[d] = 1'b0;
      end else begin
        if (m_valid[d] && rsp_ready) n_valid[d] = 1'b0;
        if (m_pend[d] && (cyc + 1 == m_due[d])) begin
          n_pend[d]  = 1'b0;
          n_valid[d] = 1'b1;
          n_instr[d] = ref_mem[m_idx[d]];
        end
        if (req_valid && rdy) begin
          mis = req_pc[1:0] != 2'b00;
          err = !mis && (req_pc < 64'h8000_0000 || req_pc >= 64'h8000_4000);
          off = req_pc - 64'h8000_0000;
          n_mis[d] = mis;
          n_err[d] = err;
          if (mis || err) begin
            n_valid[d] = 1'b1;
            n_instr[d] = '0;
          end else if (lat_of(d) == 1) begin
            n_valid[d] = 1'b1;
            n_instr[d] = ref_mem[off[13:2]];
          end else begin
            n_valid[d] = 1'b0;
            n_pend[d]  = 1'b1;
            n_idx[d]   = off[13:2];
            n_due[d]   = cyc + lat_of(d);
          end
        end
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      m_pend[d] = n_pend[d];  m_valid[d] = n_valid[d]; m_due[d] = n_due[d];
      m_idx[d]  = n_idx[d];   m_instr[d] = n_instr[d]; m_mis[d] = n_mis[d];
      m_err[d]  = n_err[d];
    end
    if (wr_en) ref_mem[wr_addr] = wr_data;
    cyc++;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [63:0] rand_pc();
    int unsigned k = $urandom_range(0, 9);
    logic [63:0] w;
    if (k < 4)       w = 64'h8000_0000 + 64'($urandom_range(0, 15)) * 4;
    else if (k < 7)  w = 64'h8000_0000 + 64'($urandom_range(0, 4095)) * 4;
    else if (k == 7) w = 64'h8000_0000 + 64'($urandom_range(0, 16383));
    else if (k == 8) w = 64'h8000_3FF0 + 64'($urandom_range(0, 31));
    else             w = {32'($urandom), 32'($urandom)};
    return w;
  endfunction

  logic [63:0] err_pc  [3] = '{64'h8000_0002, 64'h8000_4000, 64'h0};
  logic        err_mis [3] = '{1'b1, 1'b0, 1'b0};
  logic [31:0] va, vb, vc, vd;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_pc = '0; flush = 1'b0; rsp_ready = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    model_reset();
    step();
    step();
    for (int d = 0; d < 2; d++) begin
      check_eq("rst_instr", 64'(rsp_instr[d]), 64'h0);
      check_eq("rst_mis", 64'(rsp_mis[d]), 64'h0);
      check_eq("rst_err", 64'(rsp_err[d]), 64'h0);
    end
    rst_n = 1'b1;
    step();

    // Preload the whole array so every fetch has a known value.
    for (int i = 0; i < 4096; i++) begin
      wr_en = 1'b1; wr_addr = 12'(i); wr_data = $urandom;
      step();
    end
    wr_en = 1'b1; wr_addr = 12'd3; wr_data = 32'h0000_0013;
    step();
    wr_en = 1'b0;

    // LATENCY=2 basic fetch.
    req_valid = 1'b1; req_pc = 64'h8000_000C;
    step();
    req_valid = 1'b0;
    check_eq("l2_not_early", 64'(rsp_valid[0]), 64'h0);
    step();
    check_eq("l2_valid", 64'(rsp_valid[0]), 64'h1);
    check_eq("l2_instr", 64'(rsp_instr[0]), 64'h13);
    idle(3);

    // LATENCY=1 streaming without bubbles.
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_pc = 64'h8000_0000 + 64'(i) * 4;
      step();
      check_eq("stream_valid", 64'(rsp_valid[1]), 64'h1);
      check_eq("stream_instr", 64'(rsp_instr[1]), 64'(ref_mem[i]));
    end
    idle(4);

    // Error requests respond after one edge on both latencies.
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_pc = err_pc[i];
      step();
      req_valid = 1'b0;
      check_eq("err_valid", 64'(rsp_valid[0]), 64'h1);
      check_eq("err_mis", 64'(rsp_mis[0]), 64'(err_mis[i]));
      check_eq("err_bus", 64'(rsp_err[0]), 64'(!err_mis[i]));
      check_eq("err_instr", 64'(rsp_instr[0]), 64'h0);
      idle(2);
    end

    // Backpressure, then handshake with a same-cycle new request.
    rsp_ready = 1'b0; req_valid = 1'b1; req_pc = 64'h8000_0010;
    for (int i = 0; i < 8; i++) step();
    check_eq("bp_ready", 64'(req_ready[0]), 64'h0);
    rsp_ready = 1'b1; req_pc = 64'h8000_0014;
    step();
    check_eq("b2b_valid", 64'(rsp_valid[1]), 64'h1);
    check_eq("b2b_instr", 64'(rsp_instr[1]), 64'(ref_mem[5]));
    idle(4);

    // Flush in WAIT with a competing request.
    req_valid = 1'b1; req_pc = 64'h8000_0018;
    step();
    req_pc = 64'h8000_001C; flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("flush_wait_l2", 64'(rsp_valid[0]), 64'h0);
    check_eq("flush_wait_l1", 64'(rsp_valid[1]), 64'h0);
    idle(4);

    // Flush in RESP beats rsp_ready and blocks acceptance.
    rsp_ready = 1'b0; req_valid = 1'b1; req_pc = 64'h8000_0020;
    step();
    req_valid = 1'b0;
    step();
    flush = 1'b1; rsp_ready = 1'b1; req_valid = 1'b1; req_pc = 64'h8000_0024;
    step();
    flush = 1'b0;
    check_eq("flush_resp_l2", 64'(rsp_valid[0]), 64'h0);
    check_eq("flush_resp_l1", 64'(rsp_valid[1]), 64'h0);
    idle(4);

    // Same-edge write and read of word 5 returns the old value.
    va = ref_mem[5]; vb = $urandom;
    req_valid = 1'b1; req_pc = 64'h8000_0014; wr_en = 1'b1; wr_addr = 12'd5; wr_data = vb;
    step();
    wr_en = 1'b0; req_valid = 1'b0;
    check_eq("wr_same_l1", 64'(rsp_instr[1]), 64'(va));
    idle(3);
    vc = $urandom; vd = $urandom;
    wr_en = 1'b1; wr_data = vc;
    step();
    wr_en = 1'b0; req_valid = 1'b1;
    step();
    req_valid = 1'b0; wr_en = 1'b1; wr_data = vd;
    step();
    wr_en = 1'b0;
    check_eq("wr_same_l2", 64'(rsp_instr[0]), 64'(vc));
    idle(3);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    check_eq("wr_new_l1", 64'(rsp_instr[1]), 64'(vd));
    step();
    check_eq("wr_new_l2", 64'(rsp_instr[0]), 64'(vd));
    idle(3);

    // Reset asserted while LATENCY=2 sits in WAIT.
    req_valid = 1'b1; req_pc = 64'h8000_0028;
    step();
    req_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_wait_l2", 64'(rsp_valid[0]), 64'h0);
    check_eq("rst_wait_l1", 64'(rsp_valid[1]), 64'h0);
    model_reset();
    step();
    step();
    rst_n = 1'b1;
    idle(5);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      req_valid = $urandom_range(0, 3) != 0;
      req_pc    = rand_pc();
      flush     = $urandom_range(0, 19) == 0;
      rsp_ready = $urandom_range(0, 3) != 0;
      wr_en     = $urandom_range(0, 7) == 0;
      wr_addr   = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 15)) : 12'($urandom);
      wr_data   = $urandom;
      step();
    end
    flush = 1'b0; wr_en = 1'b0; rsp_ready = 1'b1;
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
